// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. It oversamples rx with the system clock and
// samples each bit at its midpoint. A 1-cycle rcv strobe marks each good byte.
// A 1-cycle frame_err strobe marks a low stop bit.
module uart_rx #(
    parameter int BAUD = 104                // clock cycles per bit (B115200 at 12 MHz)
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] HALF_BIT = 16'(BAUD / 2 - 1);
    localparam logic [15:0] FULL_BIT = 16'(BAUD - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] timer, timer_nxt;
    logic [2:0]  bitcnt, bitcnt_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [7:0]  data_nxt;
    logic        rcv_nxt, ferr_nxt;
    logic        rx_sync_p0, rx_sync_p1;
    logic        rx_s;
    logic        tick;

    assign rx_s = rx_sync_p1;
    assign tick = (timer == 16'd0);
    assign busy = (state != IDLE);

    // two-flop synchronizer for the asynchronous line; idles high so reset does not fake a start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    // state, counters, output byte and strobes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            timer     <= 16'd0;
            bitcnt    <= 3'd0;
            shreg     <= 8'h00;
            data      <= 8'h00;
            rcv       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            bitcnt    <= bitcnt_nxt;
            shreg     <= shreg_nxt;
            data      <= data_nxt;
            rcv       <= rcv_nxt;
            frame_err <= ferr_nxt;
        end
    end

    // next-state logic: each tick samples mid-bit and reloads the bit timer
    always_comb begin
        state_nxt  = state;
        timer_nxt  = tick ? 16'd0 : timer - 16'd1;
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        data_nxt   = data;
        rcv_nxt    = 1'b0;
        ferr_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    timer_nxt = HALF_BIT;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_nxt  = DATA;
                        timer_nxt  = FULL_BIT;
                        bitcnt_nxt = 3'd0;
                    end else begin
                        // the line went high again by mid start bit, so treat it as a glitch
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_nxt = {rx_s, shreg[7:1]};
                    timer_nxt = FULL_BIT;
                    if (bitcnt == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bitcnt_nxt = bitcnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        data_nxt  = shreg;
                        rcv_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                // wait out a held-low line so that a break never produces bytes
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed testbench for uart_rx with BAUD=104 and a 2-unit clock period.
module tb_uart_rx;

    localparam int BAUD = 104;
    localparam int LAT  = (19 * BAUD) / 2 + 3;   // 9.5*BAUD + 3 = 991

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       rx   = 1'b1;
    logic [7:0] data;
    logic       rcv;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] rcv_q[$];
    int         rcv_cyc[$];
    int         start_q[$];
    int         ferr_cnt = 0;
    int         overlap  = 0;
    int         wide     = 0;
    logic       rcv_prev  = 1'b0;
    logic       ferr_prev = 1'b0;

    uart_rx #(.BAUD(BAUD)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx       (rx),
        .data     (data),
        .rcv      (rcv),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #1 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // record strobes on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (rcv) begin
            rcv_q.push_back(data);
            rcv_cyc.push_back(cyc);
        end
        if (frame_err) ferr_cnt++;
        if (rcv && frame_err) overlap++;
        if ((rcv && rcv_prev) || (frame_err && ferr_prev)) wide++;
        rcv_prev  = rcv;
        ferr_prev = frame_err;
    end

    // send one frame starting at a negedge. stop_low > 0 holds the stop bit low for that many bit-times
    task automatic send_frame(input logic [7:0] b, input int stop_low);
        rx = 1'b0;
        if (stop_low == 0) start_q.push_back(cyc);
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        if (stop_low > 0) begin
            rx = 1'b0;
            repeat (BAUD * stop_low) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rx   = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (data !== 8'h00 || rcv !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: data=%h rcv=%b ferr=%b busy=%b, expected 00 0 0 0",
                     data, rcv, frame_err, busy);
        end
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single();
        int n0 = rcv_q.size();
        int f0 = ferr_cnt;
        send_frame(8'h55, 0);
        repeat (BAUD) @(negedge clk);
        checks++;
        if (rcv_q.size() - n0 != 1) begin
            errors++;
            $display("FAIL single_count: got %0d pulses expected 1", rcv_q.size() - n0);
        end else begin
            checks++;
            if (rcv_q[n0] !== 8'h55) begin
                errors++;
                $display("FAIL single_data: got %h expected 55", rcv_q[n0]);
            end
        end
        checks++;
        if (ferr_cnt != f0) begin
            errors++;
            $display("FAIL single_ferr: got %0d frame errors expected 0", ferr_cnt - f0);
        end
        checks++;
        if (busy !== 1'b0 || data !== 8'h55) begin
            errors++;
            $display("FAIL single_idle: busy=%b data=%h expected 0 55", busy, data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3] = '{8'hA3, 8'h00, 8'hFF};
        int n0 = rcv_q.size();
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 0);
        repeat (BAUD) @(negedge clk);
        checks++;
        if (rcv_q.size() - n0 != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses expected 3", rcv_q.size() - n0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rcv_q[n0 + i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL b2b_data%0d: got %h expected %h", i, rcv_q[n0 + i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int n0 = rcv_q.size();
        int f0 = ferr_cnt;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_high: got %b expected 1", busy);
        end
        rx = 1'b1;
        repeat (BAUD) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rcv_q.size() != n0 || ferr_cnt != f0) begin
            errors++;
            $display("FAIL glitch_idle: busy=%b rcv_pulses=%0d ferr=%0d expected 0 0 0",
                     busy, rcv_q.size() - n0, ferr_cnt - f0);
        end
    endtask

    task automatic test_frame_err();
        int n0 = rcv_q.size();
        int f0 = ferr_cnt;
        send_frame(8'h3C, 3);
        checks++;
        if (ferr_cnt - f0 != 1 || rcv_q.size() != n0) begin
            errors++;
            $display("FAIL ferr_pulse: ferr=%0d rcv=%0d expected 1 0", ferr_cnt - f0, rcv_q.size() - n0);
        end
        checks++;
        if (data !== 8'hFF || busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_hold: data=%h busy=%b expected ff 0", data, busy);
        end
        send_frame(8'h41, 0);
        repeat (BAUD) @(negedge clk);
        checks++;
        if (rcv_q.size() - n0 != 1 || data !== 8'h41) begin
            errors++;
            $display("FAIL ferr_recover: pulses=%0d data=%h expected 1 41", rcv_q.size() - n0, data);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b = 8'h5A;
        int n0 = rcv_q.size();
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = b[4];
        repeat (BAUD / 2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy: got %b expected 1", busy);
        end
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || data !== 8'h00) begin
            errors++;
            $display("FAIL midframe_reset: busy=%b data=%h expected 0 00", busy, data);
        end
        rx   = 1'b1;
        rstn = 1'b1;
        repeat (12 * BAUD) @(negedge clk);
        checks++;
        if (rcv_q.size() != n0) begin
            errors++;
            $display("FAIL midframe_drop: got %0d pulses expected 0", rcv_q.size() - n0);
        end
        send_frame(8'h12, 0);
        repeat (BAUD) @(negedge clk);
        checks++;
        if (rcv_q.size() - n0 != 1 || data !== 8'h12) begin
            errors++;
            $display("FAIL midframe_next: pulses=%0d data=%h expected 1 12", rcv_q.size() - n0, data);
        end
    endtask

    task automatic test_timing();
        checks++;
        if (rcv_q.size() != start_q.size() || rcv_q.size() != 6) begin
            errors++;
            $display("FAIL timing_count: rcv=%0d starts=%0d expected 6 6", rcv_q.size(), start_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                int lat = rcv_cyc[i] - start_q[i];
                checks++;
                if (lat < LAT - 1 || lat > LAT + 1) begin
                    errors++;
                    $display("FAIL timing_latency%0d: got %0d cycles expected %0d +/-1", i, lat, LAT);
                end
            end
        end
        checks++;
        if (overlap != 0 || wide != 0) begin
            errors++;
            $display("FAIL pulse_shape: overlaps=%0d wide=%0d expected 0 0", overlap, wide);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_timing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
